// File: rtl/dmem_mmio.sv
// dmem_mmio: word-organised data RAM with byte/half lanes plus a small MMIO window (LED, cycle counter, store-fault status).
// Rev 1.0
`default_nettype none

module dmem_mmio #(
  parameter int DEPTH_LOG2 = 7,
  parameter int LED_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_w,
  input  logic [31:0]      Addr_in,
  input  logic [31:0]      Data_in,
  input  logic [2:0]       DMType,
  output logic [31:0]      Data_out,
  output logic [LED_W-1:0] led_out,
  output logic             fault,
  output logic [31:0]      fault_addr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [15:0] OFF_LED   = 16'h0000;
  localparam logic [15:0] OFF_CYCLE = 16'h0004;
  localparam logic [15:0] OFF_FSTAT = 16'h0008;
  localparam logic [15:0] OFF_FADDR = 16'h000C;

  logic [31:0]           ram [DEPTH];
  logic [31:0]           cycle_cnt;
  logic [7:0]            fault_cnt;

  logic                  is_half, is_byte, is_word, is_mmio, aligned;
  logic                  wr_ok, st_fault, ram_we, mmio_we;
  logic [15:0]           offset;
  logic [DEPTH_LOG2-1:0] idx;
  logic [3:0]            be;
  logic [31:0]           wdata, rd_word, shifted, wr_word, load_val;

  assign is_half = (DMType == 3'b001) || (DMType == 3'b010);
  assign is_byte = (DMType == 3'b011) || (DMType == 3'b100);
  assign is_word = !is_half && !is_byte;
  assign is_mmio = (Addr_in[31:16] == 16'hFFFF);
  assign offset  = Addr_in[15:0];
  assign idx     = Addr_in[DEPTH_LOG2+1:2];

  // MMIO only takes aligned word accesses; anything else is a misaligned access.
  assign aligned = is_mmio ? (is_word && Addr_in[1:0] == 2'b00) :
                   is_word ? (Addr_in[1:0] == 2'b00) :
                   is_half ? !Addr_in[0] : 1'b1;

  assign wr_ok    = mem_w && aligned;
  assign st_fault = mem_w && !aligned;
  assign ram_we   = wr_ok && !is_mmio;
  assign mmio_we  = wr_ok && is_mmio;

  always_comb begin
    be    = 4'hF;
    wdata = Data_in;
    if (is_byte) begin
      be    = 4'b0001 << Addr_in[1:0];
      wdata = {4{Data_in[7:0]}};
    end else if (is_half) begin
      be    = Addr_in[1] ? 4'b1100 : 4'b0011;
      wdata = {2{Data_in[15:0]}};
    end
  end

  assign rd_word = ram[idx];
  assign shifted = rd_word >> {Addr_in[1:0], 3'b000};

  always_comb begin
    wr_word = rd_word;
    for (int l = 0; l < 4; l++) begin
      if (be[l]) wr_word[8*l +: 8] = wdata[8*l +: 8];
    end
  end

  always_comb begin
    load_val = 32'h0;
    if (aligned) begin
      if (is_mmio) begin
        case (offset)
          OFF_LED:   load_val = 32'(led_out);
          OFF_CYCLE: load_val = cycle_cnt;
          OFF_FSTAT: load_val = {16'h0, fault_cnt, 7'h0, fault};
          OFF_FADDR: load_val = fault_addr;
          default:   load_val = 32'h0;
        endcase
      end else begin
        case (DMType)
          3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
          3'b010:  load_val = {16'h0, shifted[15:0]};
          3'b011:  load_val = {{24{shifted[7]}}, shifted[7:0]};
          3'b100:  load_val = {24'h0, shifted[7:0]};
          default: load_val = rd_word;
        endcase
      end
    end
  end

  assign Data_out = load_val;

  genvar w;
  generate
    for (w = 0; w < DEPTH; w++) begin : g_word
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          ram[w] <= 32'h0;
        end else if (ram_we && idx == DEPTH_LOG2'(w)) begin
          ram[w] <= wr_word;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_out    <= '0;
      cycle_cnt  <= 32'h0;
      fault      <= 1'b0;
      fault_cnt  <= 8'h0;
      fault_addr <= 32'h0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'h1;
      if (mmio_we && offset == OFF_CYCLE) cycle_cnt <= Data_in;
      if (mmio_we && offset == OFF_LED) led_out <= Data_in[LED_W-1:0];
      // A faulting store never writes state, so a misaligned FSTAT write records rather than clears.
      if (st_fault) begin
        fault <= 1'b1;
        if (fault_cnt != 8'hFF) fault_cnt <= fault_cnt + 8'h1;
        if (!fault) fault_addr <= Addr_in;
      end else if (mmio_we && offset == OFF_FSTAT) begin
        fault      <= 1'b0;
        fault_cnt  <= 8'h0;
        fault_addr <= 32'h0;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/dmem_mmio.md
# dmem_mmio

Data-memory stage of the pipelined RISC-V core, directly downstream of the CPU's MEM-stage outputs (ALU address, store data, DMType, memory-write strobe). It holds a word-organised RAM with byte/halfword lane handling. It also decodes a small memory-mapped I/O window: an LED register, a free-running cycle counter, and a store-fault status register. Load data returns combinationally so the CPU's MEM/WB register captures it in the same cycle.

## Interface
Parameters:
- DEPTH_LOG2, default 7 — RAM holds 2^DEPTH_LOG2 32-bit words (512 B by default).
- LED_W, default 16 — width of the LED register.

Ports:
- clk — input, 1 — single clock; all state updates on its rising edge.
- rst — input, 1 — reset is asynchronous and active-low.
- mem_w — input, 1 — store strobe, valid for the current cycle.
- Addr_in — input, 32 — byte address.
- Data_in — input, 32 — store data, right-aligned in the low lanes.
- DMType — input, 3 — access type:
  - 000 word
  - 001 half signed
  - 010 half unsigned
  - 011 byte signed
  - 100 byte unsigned
  - 101–111 treated as word
- Data_out — output, 32 — load data, combinational, extended per DMType.
- led_out — output, LED_W — LED register.
- fault — output, 1 — sticky store-fault flag.
- fault_addr — output, 32 — address of the first faulting store since the last clear.

## Operation
Address decode:
- MMIO when Addr_in[31:16] == 16'hFFFF.
- Otherwise RAM, with word index Addr_in[DEPTH_LOG2+1:2]. Upper address bits are ignored, so RAM aliases.

Alignment rules:
- Word access requires Addr_in[1:0] == 0.
- Half access requires Addr_in[0] == 0.
- Byte access is always aligned.
- MMIO accepts word accesses only. Any non-word MMIO access counts as misaligned.

RAM store, when mem_w=1 and the access is aligned:
- Byte: Data_in[7:0] goes to lane Addr_in[1:0].
- Half: Data_in[15:0] goes to lanes {Addr_in[1],0} and {Addr_in[1],1}.
- Word: all four lanes are written.
- Unselected lanes keep their contents.

RAM load:
- The selected lane(s) are shifted to bit 0, then sign-extended (types 001, 011) or zero-extended (010, 100).
- A misaligned load returns 32'h0 and leaves all state unchanged.

MMIO map, offset = Addr_in[15:0]:
- 0x0000 LED:
  - Write loads Data_in[LED_W-1:0].
  - Read returns the value zero-extended.
- 0x0004 CYCLE:
  - Read returns the counter.
  - Write loads Data_in into the counter.
- 0x0008 FSTAT:
  - Read returns {16'h0, fault_cnt[7:0], 7'h0, fault}.
  - Any write clears fault, fault_cnt and fault_addr.
- 0x000C FADDR: read returns fault_addr; writes are ignored.
- Any other offset reads 32'h0; writes to it are ignored with no fault.

Store fault (mem_w=1 and misaligned):
- No RAM or MMIO state is written.
- fault is set to 1.
- fault_cnt increments and saturates at 8'hFF.
- fault_addr captures Addr_in only if fault was 0 beforehand.

Cycle counter:
- 32 bits, increments every cycle, wraps from 32'hFFFF_FFFF to 0.

## Timing
- Reset (rst=0, asynchronous):
  - All RAM words = 0, led_out = 0, counter = 0.
  - fault = 0, fault_cnt = 0, fault_addr = 0.
  - Data_out follows the combinational path on the reset state.
- Stores: committed on the rising edge where mem_w=1.
  - A load from the same address in the same cycle returns the old data.
  - The next cycle returns the new data.
- Load latency: 0 cycles. Data_out is a pure function of Addr_in, DMType and current state.
- Counter write versus increment in the same cycle: the write wins. The loaded value is visible next cycle and increments the cycle after.
- A faulting store whose address is FSTAT: the fault is recorded and the clear is not performed (no state write on fault).
- A FSTAT clear while fault=1: the flag clears on that edge. The next faulting store recaptures fault_addr.
- Reset asserted mid-operation overrides any store in the same cycle. No partial lane update survives.

## Test plan
- Reset, then store word 0x8765_4321 at 0x10. Then:
  - lb at 0x13 -> 0xFFFF_FF87
  - lbu at 0x13 -> 0x0000_0087
  - lh at 0x12 -> 0xFFFF_8765
  - lhu at 0x10 -> 0x0000_4321
- Store byte 0xAA at 0x21 over word 0x1122_3344 -> lw at 0x20 returns 0x1122_AA44. Same-cycle read shows 0x1122_3344; next cycle shows the new word.
- Store half at 0x31, then word at 0x42 -> both are suppressed, fault=1, fault_addr=0x31. FSTAT reads 0x0000_0201. A write to FSTAT clears it to 0.
- Write 0xFFFF_FFFE to CYCLE -> reads over the following cycles give 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000. Write LED 0x1_5A5A with LED_W=16 -> led_out=0x5A5A.
- Store byte to 0xFFFF_0000 -> LED unchanged and fault=1. An lbu from MMIO returns 0.
- Assert rst asynchronously between edges after several stores -> all outputs are 0 immediately. After release, every RAM word reads 0.
